// File: rtl/axis_depacketizer_pkg.sv
// axis_depacketizer_pkg: shared state and length-check types for the depacketizer.
package axis_depacketizer_pkg;
  typedef enum logic {SYNC, RUN} state_t;
  typedef enum logic [1:0] {OK, SHORT, LONG} len_res_t;
  function automatic len_res_t classify(input int unsigned len, input int unsigned cfg);
    return (len == cfg + 1) ? OK : (len < cfg + 1) ? SHORT : LONG;
  endfunction
endpackage

// File: rtl/axis_depacketizer_if.sv
// axis_depacketizer_if: AXI4-Stream bundle with master/slave views.
interface axis_depacketizer_if #(parameter int AXIS_TDATA_WIDTH = 32);
  logic [AXIS_TDATA_WIDTH-1:0] tdata;
  logic tvalid;
  logic tready;
  logic tlast;
  modport master (output tdata, tvalid, tlast, input tready);
  modport slave (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: 2-entry output stage, 1-cycle latency, registered upstream ready.
module axis_skid_buffer #(parameter int AXIS_TDATA_WIDTH = 32) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        in_valid,
  input  logic [AXIS_TDATA_WIDTH-1:0] in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [AXIS_TDATA_WIDTH-1:0] out_data,
  input  logic                        out_ready
);
  logic [AXIS_TDATA_WIDTH-1:0] mem [2];
  logic rd;
  logic [1:0] count, count_nxt;
  logic push, pop, wr;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign wr = rd ^ count[0];
  assign count_nxt = count + {1'b0, push} - {1'b0, pop};
  assign out_valid = count != 2'd0;
  assign out_data = mem[rd];
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mem <= '{default: '0};
      rd <= 1'b0;
      count <= 2'd0;
      in_ready <= 1'b0;
    end else begin
      if (push) mem[wr] <= in_data;
      if (pop) rd <= ~rd;
      count <= count_nxt;
      in_ready <= count_nxt != 2'd2;
    end
  end
endmodule

// File: rtl/axis_depacketizer.sv
// axis_depacketizer: strips tlast framing, checks packet length against cfg_data, counts good/bad packets.
// Define AXIS_DEPACKETIZER_DROP_EN to discard the overlength tail of long packets.
module axis_depacketizer
  import axis_depacketizer_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [CNTR_WIDTH-1:0] cfg_data,
  output logic [CNTR_WIDTH-1:0] sts_good,
  output logic [CNTR_WIDTH-1:0] sts_err,
  output logic                  sts_sync,
  axis_depacketizer_if.slave    s_axis,
  axis_depacketizer_if.master   m_axis
);
  state_t state, state_nxt;
  logic [CNTR_WIDTH-1:0] cnt;
  logic in_ready, acc, run_beat, keep, fwd, out_valid;
  logic [AXIS_TDATA_WIDTH-1:0] out_data;
  assign acc = s_axis.tvalid & in_ready;
  assign run_beat = acc & (state == RUN);
`ifdef AXIS_DEPACKETIZER_DROP_EN
  assign keep = cnt <= cfg_data;
`else
  assign keep = 1'b1;
`endif
  assign fwd = run_beat & keep;
  assign sts_sync = state == RUN;
  assign s_axis.tready = in_ready;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata = out_data;
  assign m_axis.tlast = 1'b0;
  always_comb begin
    state_nxt = state;
    if (state == SYNC && acc && s_axis.tlast) state_nxt = RUN;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= SYNC;
    else state <= state_nxt;
  end
  // A saturated counter still mismatches any cfg_data below all-ones, so long packets stay errors.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= '0;
      sts_good <= '0;
      sts_err <= '0;
    end else if (run_beat) begin
      if (s_axis.tlast) begin
        cnt <= '0;
        if (cnt == cfg_data) sts_good <= sts_good + 1'b1;
        else sts_err <= sts_err + 1'b1;
      end else if (~&cnt) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
  axis_skid_buffer #(.AXIS_TDATA_WIDTH(AXIS_TDATA_WIDTH)) u_skid (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (fwd),
    .in_data   (s_axis.tdata),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (m_axis.tready)
  );
endmodule

// File: doc/axis_depacketizer.md
# axis_depacketizer

Receive-side counterpart of the packetizer. Consumes a framed AXI4-Stream whose packets end with `s_axis_tlast`, checks each packet length against `cfg_data`, forwards payload with `tlast` stripped, and keeps good/error packet counters. Sits between a packet source (DMA reader, network RX) and unframed sample consumers.

## Interface
- `AXIS_TDATA_WIDTH`, default 32: data width.
- `CNTR_WIDTH`, default 32: width of the beat counter, `cfg_data` and status counters.
- `aclk`  in  1  clock.
- `aresetn`  in  1  asynchronous active-low reset.
- `cfg_data`  in  CNTR_WIDTH  expected packet length minus one (index of the last beat).
- `sts_good`  out  CNTR_WIDTH  count of packets with correct length.
- `sts_err`  out  CNTR_WIDTH  count of packets with wrong length.
- `sts_sync`  out  1  high once framing is acquired.
- `s_axis_tready`  out  1  slave ready.
- `s_axis_tdata`  in  AXIS_TDATA_WIDTH  slave data.
- `s_axis_tvalid`  in  1  slave valid.
- `s_axis_tlast`  in  1  packet end marker.
- `m_axis_tready`  in  1  master ready.
- `m_axis_tdata`  out  AXIS_TDATA_WIDTH  payload.
- `m_axis_tvalid`  out  1  master valid.

## Operation
- Accepted beat: `s_axis_tvalid & s_axis_tready`.
- FSM states: SYNC (reset state) and RUN.
  - SYNC: accepted beats are discarded. An accepted beat with `tlast` moves to RUN with `cnt` = 0. Counters are not touched. `sts_sync` = 0.
  - RUN: `sts_sync` = 1. Stays in RUN until reset.
- RUN, accepted beat with `tlast` = 0:
  - beat forwarded;
  - `cnt` increments, saturating at all-ones.
- RUN, accepted beat with `tlast` = 1:
  - beat forwarded;
  - if `cnt == cfg_data`, `sts_good` increments; otherwise `sts_err` increments (short or long);
  - `cnt` returns to 0.
- Status counters wrap modulo 2^CNTR_WIDTH.
- `cfg_data` is compared live. A change mid-packet applies to the current packet's `tlast` check.
- Comparisons are unsigned, full CNTR_WIDTH.

## Timing
- Output stage is a 2-entry skid buffer.
  - Latency input to output is 1 cycle.
  - Full throughput of 1 beat/cycle under continuous `m_axis_tready`.
- `s_axis_tready` is registered: high when the skid buffer holds at most one entry.
- In SYNC, and for dropped beats, the beat is accepted but not written into the buffer.
- `m_axis_tvalid` holds with stable `m_axis_tdata` until `m_axis_tready`.
- No data loss or reordering under any `m_axis_tready` pattern.
- Status counters update the cycle after the `tlast` beat is accepted, independent of output backpressure.
- Reset values (asynchronous, take effect immediately):
  - `m_axis_tvalid` = 0, `m_axis_tdata` = 0;
  - `s_axis_tready` = 0, rising on the first clock edge after deassertion;
  - `sts_good` = `sts_err` = 0, `sts_sync` = 0;
  - `cnt` = 0, state SYNC;
  - buffered beats are discarded.
- Reset mid-packet forces re-acquisition: the remainder of the interrupted packet is dropped in SYNC.

## Configuration
- `AXIS_DEPACKETIZER_DROP_EN` defined:
  - In RUN, accepted beats arriving while `cnt > cfg_data` (overlength tail) are discarded, including the terminating `tlast` beat.
  - Every forwarded packet is therefore at most `cfg_data`+1 beats. The error is still counted.
- Not defined: all RUN beats are forwarded, overlength packets included; only the error counter records them.
- Short packets are forwarded in both cases.

## Structure
- Package `axis_depacketizer_pkg`:
  - state enum (SYNC, RUN);
  - length-check result enum (OK, SHORT, LONG), used by the bench for expected-value classification.
- Sub-module `axis_skid_buffer` (parameter AXIS_TDATA_WIDTH): the 2-entry output stage.
- FSM, beat counter, comparison and status counters live in the top module.

## Test plan
All scenarios use `cfg_data` = 3 unless stated.
1. Start mid-packet after reset: send 2 beats, then a `tlast` beat, then a 4-beat packet (data 0xA0–0xA3) → first 3 beats dropped; `sts_sync` rises after the third beat; 0xA0–0xA3 out in order; `sts_good` = 1, `sts_err` = 0.
2. Short packet of 2 beats after sync → both beats forwarded; `sts_err` = 1; next 4-beat packet gives `sts_good` +1.
3. Long packet of 6 beats:
   - without `AXIS_DEPACKETIZER_DROP_EN`: 6 beats out, `sts_err` = 1;
   - with it: only the first 4 beats out, `sts_err` = 1, the next packet is handled normally.
4. Random `s_axis_tvalid` and 50% random `m_axis_tready`, 100 good packets → output equals input payload exactly; `sts_good` = 100; never more than 1 beat/cycle.
5. Assert `aresetn` low while `m_axis_tvalid` = 1 mid-packet → `m_axis_tvalid` and counters zero without a clock edge; after release, state SYNC and the partial packet is dropped.
6. `CNTR_WIDTH` = 4, `cfg_data` = 0, 17 single-beat `tlast` packets after sync → `sts_good` wraps to 1; `sts_err` = 0.
